pulse_to_led: RTL and testbench
===============================

# pulse_to_led

Output-side companion to the button debouncer: turns single-cycle event pulses into human-visible LED blinks on the Zedboard. Each accepted pulse produces exactly one blink: LED on for `ON_CYCLES`, then off for `GAP_CYCLES`. Pulses that arrive mid-blink are queued in a saturating pending counter, so N pulses give N distinct blinks. It sits between FPU status/event strobes (result valid, exception flags) and the board LEDs.

## Interface
Parameters:
- `ON_CYCLES`, 10000000: LED-on duration in clk cycles (0.1 s at 100 MHz); must be ≥1.
- `GAP_CYCLES`, 10000000: forced LED-off gap after each blink; must be ≥1.
- `CNT_W`, 4: pending-counter width; max queued blinks = 2^CNT_W − 1.

Ports:
- `clk`  in  1  system clock, 100 MHz.
- `rst_n`  in  1  reset; one clock; reset is asynchronous and active-low.
- `pulse_in`  in  1  single-cycle event strobe, synchronous to `clk`.
- `ovf_clr`  in  1  clears the sticky `overflow` flag.
- `led`  out  1  registered LED drive.
- `busy`  out  1  high whenever the state is not IDLE.
- `pending`  out  CNT_W  blinks queued beyond the current one.
- `overflow`  out  1  sticky; a pulse was dropped because `pending` was saturated.

## Operation
- FSM states: IDLE, ON, GAP. The duration counter is `$clog2(max(ON_CYCLES,GAP_CYCLES))+1` bits wide. It is loaded on each state entry and counts down to 1.
- IDLE: `pulse_in`=1 → ON. The pulse is consumed and `pending` is unchanged.
- ON: `led`=1. When the counter expires → GAP.
- GAP: `led`=0. When the counter expires:
  - if `pending`>0, decrement it → ON;
  - else if `pulse_in`=1 on that same edge, consume the pulse → ON;
  - else → IDLE.
- `pulse_in` in ON or GAP, when not consumed as above:
  - `pending`<max: `pending`+1;
  - `pending`=max: pulse dropped, `overflow`←1.
- Increment and decrement on the same edge: `pending` is unchanged, and the blink starts.
- `pulse_in` held high for k cycles counts as k pulses. Callers must drive single-cycle strobes, e.g. the debouncer output.
- `ovf_clr`: `overflow`←0 unless a drop occurs on the same edge. In that case set wins.
- `rst_n` low at any time, including mid-blink, immediately forces IDLE. Pending is discarded and the counter is zeroed.

## Timing
- Reset values: `led`=0, `busy`=0, `pending`=0, `overflow`=0.
- All outputs are registered; no combinational path from an input to an output.
- Latency: `pulse_in` sampled high at edge k in IDLE → `led`=1 after edge k. `led` stays high for exactly ON_CYCLES cycles, then low for exactly GAP_CYCLES cycles.
- Back-to-back blinks: the period is exactly ON_CYCLES+GAP_CYCLES. There is no idle cycle between GAP expiry and the next ON.
- `busy` goes high after the accepting edge. It goes low after the GAP-expiry edge that enters IDLE.
- On `rst_n` deassertion, the first pulse can be accepted on the first following rising edge.

## Structure
- Shared package `led_pkg`:
  - state encoding typedef (IDLE/ON/GAP);
  - constants `CLK_HZ`=100000000 and `BLINK_100MS`=10000000, which the debouncer threshold should also use.
- One natural sub-module, `down_timer`: a loadable down-counter with `load`, `value` and `expired` signals, parameterised by width.
- The FSM, pending counter and overflow flag stay in `pulse_to_led`.

## Test plan
Bench parameters: ON_CYCLES=4, GAP_CYCLES=3, CNT_W=2.
- **Reset mid-ON.** Stimulus: pulse in IDLE, then `rst_n` low 2 cycles into ON. Response: `led` rises 1 edge after the pulse; all outputs 0 immediately on `rst_n` low, before any clock edge.
- **Single pulse.** Stimulus: one pulse. Response: `led` high 4 cycles, low 3 cycles; `busy` high for 7 cycles; `pending` stays 0.
- **Queued blinks.** Stimulus: 3 pulses during ON. Response: `pending`=3; 4 blinks back-to-back with period 7; `pending` goes 3→2→1→0 at each GAP expiry.
- **Overflow and clear.** Stimulus: 4 pulses during ON. Response: `pending`=3, `overflow`=1, 4 blinks total. Stimulus: `ovf_clr` together with a 5th drop. Response: `overflow` stays 1. Stimulus: `ovf_clr` alone. Response: `overflow`=0.
- **Pulse on GAP-expiry edge.** Stimulus: pulse exactly on the GAP-expiry edge with `pending`=0. Response: ON re-entered with no IDLE cycle; `pending` stays 0.
- **Increment and decrement together.** Stimulus: pulse on the GAP-expiry edge with `pending`=1. Response: `pending` stays 1 and the next blink starts.

Source files
------------

// File: rtl/led_pkg.sv
// Shared definitions for the LED-side event indicators: blink FSM states and
// board timing constants (also used by the button debouncer threshold).
package led_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        GAP  = 2'd2
    } led_state_t;

    localparam int unsigned CLK_HZ      = 100_000_000;
    localparam int unsigned BLINK_100MS = 10_000_000;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pulse_to_led_down_timer.sv
// Loadable down-counter: loads on request, then counts down and rests at zero.
// `expired` flags the final counted cycle (value of 1).
module down_timer #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] value,
    output logic             expired
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            value <= '0;
        end else if (load) begin
            value <= load_value;
        end else if (value != '0) begin
            value <= value - WIDTH'(1);
        end
    end

    always_comb begin
        expired = (value == WIDTH'(1));
    end

endmodule

// File: rtl/pulse_to_led.sv
// Turns single-cycle event strobes into visible LED blinks (on, then forced gap),
// queueing strobes that arrive mid-blink in a saturating pending counter.
module pulse_to_led
    import led_pkg::*;
#(
    parameter int unsigned ON_CYCLES  = BLINK_100MS,
    parameter int unsigned GAP_CYCLES = BLINK_100MS,
    parameter int unsigned CNT_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pulse_in,
    input  logic             ovf_clr,
    output logic             led,
    output logic             busy,
    output logic [CNT_W-1:0] pending,
    output logic             overflow
);

    localparam int unsigned         MAX_CYCLES = max_u(ON_CYCLES, GAP_CYCLES);
    localparam int unsigned         TW         = $clog2(MAX_CYCLES) + 1;
    localparam logic [TW-1:0]       ON_LOAD    = TW'(ON_CYCLES);
    localparam logic [TW-1:0]       GAP_LOAD   = TW'(GAP_CYCLES);
    localparam logic [CNT_W-1:0]    PEND_MAX   = '1;

    led_state_t      state;
    logic            start_on;
    logic            to_gap;
    logic            to_idle;
    logic            inc;
    logic            dec;
    logic            drop;
    logic            timer_load;
    logic [TW-1:0]   timer_load_value;
    logic [TW-1:0]   timer_value;
    logic            timer_expired;

    down_timer #(
        .WIDTH(TW)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (timer_load),
        .load_value (timer_load_value),
        .value      (timer_value),
        .expired    (timer_expired)
    );

    // A pulse not consumed to start a blink is queued, or dropped when saturated.
    always_comb begin
        start_on = 1'b0;
        to_gap   = 1'b0;
        to_idle  = 1'b0;
        inc      = 1'b0;
        dec      = 1'b0;
        drop     = 1'b0;
        unique case (state)
            IDLE: begin
                start_on = pulse_in;
            end
            ON: begin
                to_gap = timer_expired;
                if (pulse_in) begin
                    inc  = (pending != PEND_MAX);
                    drop = (pending == PEND_MAX);
                end
            end
            GAP: begin
                if (timer_expired && pending != '0) begin
                    dec      = 1'b1;
                    start_on = 1'b1;
                    if (pulse_in) begin
                        inc  = (pending != PEND_MAX);
                        drop = (pending == PEND_MAX);
                    end
                end else if (timer_expired) begin
                    start_on = pulse_in;
                    to_idle  = !pulse_in;
                end else if (pulse_in) begin
                    inc  = (pending != PEND_MAX);
                    drop = (pending == PEND_MAX);
                end
            end
            default: begin
                to_idle = 1'b1;
            end
        endcase
    end

    always_comb begin
        timer_load       = start_on | to_gap;
        timer_load_value = start_on ? ON_LOAD : GAP_LOAD;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            led      <= 1'b0;
            busy     <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            if (start_on) begin
                state <= ON;
                led   <= 1'b1;
                busy  <= 1'b1;
            end else if (to_gap) begin
                state <= GAP;
                led   <= 1'b0;
            end else if (to_idle) begin
                state <= IDLE;
                led   <= 1'b0;
                busy  <= 1'b0;
            end

            if (inc && !dec) begin
                pending <= pending + CNT_W'(1);
            end else if (dec && !inc) begin
                pending <= pending - CNT_W'(1);
            end

            if (drop) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pulse_to_led.sv
// Directed bench for pulse_to_led with ON_CYCLES=4, GAP_CYCLES=3, CNT_W=2.
module tb_pulse_to_led;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pulse_in;
    logic       ovf_clr;
    logic       led;
    logic       busy;
    logic [1:0] pending;
    logic       overflow;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    always #5 clk = ~clk;

    pulse_to_led #(
        .ON_CYCLES  (4),
        .GAP_CYCLES (3),
        .CNT_W      (2)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .pulse_in (pulse_in),
        .ovf_clr  (ovf_clr),
        .led      (led),
        .busy     (busy),
        .pending  (pending),
        .overflow (overflow)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected LED for t cycles after the accepting edge, with n blinks back-to-back.
    function automatic logic exp_led(input int t, input int n);
        return (t < 7 * n) && ((t % 7) < 4);
    endfunction

    // Pending after edge A+t when pulses arrive at A..A+3 (4th queued one dropped if more).
    function automatic logic [1:0] exp_pending_q(input int t);
        if (t < 3)  return 2'(t);
        if (t < 7)  return 2'd3;
        if (t < 14) return 2'd2;
        if (t < 21) return 2'd1;
        return 2'd0;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0; pulse_in = 1'b0; ovf_clr = 1'b0;
        step(); step();
        n_checks++;
        if ({led, busy, pending, overflow} !== 5'b0)
            $display("FAIL reset_init: got %b want 00000", {led, busy, pending, overflow});
        else n_pass++;
        rst_n = 1'b1;
        pulse_in = 1'b1;
        step();
        pulse_in = 1'b0;
        n_checks++;
        if (led !== 1'b1 || busy !== 1'b1)
            $display("FAIL reset_first_accept: led=%b busy=%b want 1 1", led, busy);
        else n_pass++;
        step(); step();
        #2 rst_n = 1'b0;
        #1;
        n_checks++;
        if ({led, busy, pending, overflow} !== 5'b0)
            $display("FAIL reset_async_mid_on: got %b want 00000", {led, busy, pending, overflow});
        else n_pass++;
        step();
        rst_n = 1'b1;
        step();
        n_checks++;
        if ({led, busy, pending, overflow} !== 5'b0)
            $display("FAIL reset_after_release: got %b want 00000", {led, busy, pending, overflow});
        else n_pass++;
    endtask

    task automatic test_single();
        for (int t = 0; t <= 8; t++) begin
            pulse_in = (t == 0);
            step();
            n_checks++;
            if (led !== exp_led(t, 1))
                $display("FAIL single_led t=%0d: got %b want %b", t, led, exp_led(t, 1));
            else n_pass++;
            n_checks++;
            if (busy !== (t < 7))
                $display("FAIL single_busy t=%0d: got %b want %b", t, busy, (t < 7));
            else n_pass++;
            n_checks++;
            if (pending !== 2'd0)
                $display("FAIL single_pending t=%0d: got %0d want 0", t, pending);
            else n_pass++;
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_queued();
        for (int t = 0; t <= 29; t++) begin
            pulse_in = (t <= 3);
            step();
            n_checks++;
            if (led !== exp_led(t, 4))
                $display("FAIL queued_led t=%0d: got %b want %b", t, led, exp_led(t, 4));
            else n_pass++;
            n_checks++;
            if (busy !== (t < 28))
                $display("FAIL queued_busy t=%0d: got %b want %b", t, busy, (t < 28));
            else n_pass++;
            n_checks++;
            if (pending !== exp_pending_q(t))
                $display("FAIL queued_pending t=%0d: got %0d want %0d", t, pending, exp_pending_q(t));
            else n_pass++;
            n_checks++;
            if (overflow !== 1'b0)
                $display("FAIL queued_overflow t=%0d: got %b want 0", t, overflow);
            else n_pass++;
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_overflow();
        logic exp_ovf;
        for (int t = 0; t <= 29; t++) begin
            pulse_in = (t <= 5);
            ovf_clr  = (t == 5) || (t == 6);
            step();
            exp_ovf = (t == 4) || (t == 5);
            n_checks++;
            if (overflow !== exp_ovf)
                $display("FAIL ovf_flag t=%0d: got %b want %b", t, overflow, exp_ovf);
            else n_pass++;
            n_checks++;
            if (pending !== exp_pending_q(t))
                $display("FAIL ovf_pending t=%0d: got %0d want %0d", t, pending, exp_pending_q(t));
            else n_pass++;
            n_checks++;
            if (led !== exp_led(t, 4))
                $display("FAIL ovf_led t=%0d: got %b want %b", t, led, exp_led(t, 4));
            else n_pass++;
        end
        pulse_in = 1'b0;
        ovf_clr  = 1'b0;
    endtask

    task automatic test_gap_edge_pulse();
        for (int t = 0; t <= 15; t++) begin
            pulse_in = (t == 0) || (t == 7);
            step();
            n_checks++;
            if (led !== exp_led(t, 2))
                $display("FAIL gapedge_led t=%0d: got %b want %b", t, led, exp_led(t, 2));
            else n_pass++;
            n_checks++;
            if (busy !== (t < 14))
                $display("FAIL gapedge_busy t=%0d: got %b want %b", t, busy, (t < 14));
            else n_pass++;
            n_checks++;
            if (pending !== 2'd0)
                $display("FAIL gapedge_pending t=%0d: got %0d want 0", t, pending);
            else n_pass++;
        end
        pulse_in = 1'b0;
    endtask

    task automatic test_inc_dec();
        logic [1:0] exp_p;
        for (int t = 0; t <= 22; t++) begin
            pulse_in = (t == 0) || (t == 1) || (t == 7);
            step();
            exp_p = ((t >= 1) && (t < 14)) ? 2'd1 : 2'd0;
            n_checks++;
            if (pending !== exp_p)
                $display("FAIL incdec_pending t=%0d: got %0d want %0d", t, pending, exp_p);
            else n_pass++;
            n_checks++;
            if (led !== exp_led(t, 3))
                $display("FAIL incdec_led t=%0d: got %b want %b", t, led, exp_led(t, 3));
            else n_pass++;
            n_checks++;
            if (busy !== (t < 21))
                $display("FAIL incdec_busy t=%0d: got %b want %b", t, busy, (t < 21));
            else n_pass++;
        end
        pulse_in = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_queued();
        test_overflow();
        test_gap_edge_pulse();
        test_inc_dec();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
